// File: rtl/smpc_periph_collector.sv
// SMPC INTBACK peripheral collector: streams per-port pad records into a 32-byte OREG page buffer.
// Optional SMPC_PAD_SNAPSHOT_EN freezes pad inputs at the start of fill for the whole transfer.
module smpc_periph_collector #(
    parameter int NPORTS    = 2,
    parameter int PAD_BYTES = 2,
    parameter int WAIT_CYC  = 4000
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          CE,
    input  logic                          START,
    input  logic                          CONT,
    input  logic                          BREAK,
    input  logic [NPORTS-1:0]             PAD_PRESENT,
    input  logic [NPORTS*PAD_BYTES*8-1:0] PAD_DATA,
    input  logic [4:0]                    OREG_ADDR,
    output logic [7:0]                    OREG_DATA,
    output logic                          BUSY,
    output logic                          NPE,
    output logic                          PDL,
    output logic                          IRQ_N
);
    localparam int WCNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int PORT_W = $clog2(NPORTS + 1);
    localparam int PH_W   = $clog2(PAD_BYTES + 2);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_FILL, ST_CLEAR, ST_PAGE_WAIT} state_t;

    state_t              state, state_n;
    logic [WCNT_W-1:0]   wait_cnt, wait_n;
    logic [4:0]          idx, idx_n;
    logic [PORT_W-1:0]   port_cur, port_n;
    logic [PH_W-1:0]     phase, phase_n;
    logic                npe_q, npe_n, pdl_q, pdl_n, irq_q, irq_n_n;
    logic                wr_en;
    logic [7:0]          wr_data;
    logic [7:0]          oreg [32];

    logic [NPORTS-1:0]             src_present;
    logic [NPORTS*PAD_BYTES*8-1:0] src_data;
    logic                          port_here, rec_last, strm_last;
    logic [7:0]                    cur_byte;
    int                            dbit;

`ifdef SMPC_PAD_SNAPSHOT_EN
    logic [NPORTS-1:0]             snap_present;
    logic [NPORTS*PAD_BYTES*8-1:0] snap_data;

    always_ff @(posedge CLK) begin
        if (CE && state == ST_WAIT && wait_cnt == '0) begin
            snap_present <= PAD_PRESENT;
            snap_data    <= PAD_DATA;
        end
    end

    assign src_present = snap_present;
    assign src_data    = snap_data;
`else
    assign src_present = PAD_PRESENT;
    assign src_data    = PAD_DATA;
`endif

    // Cursor decode: phase 0 is the F1/F0 header, 1 the length byte, 2.. the data bytes.
    always_comb begin
        port_here = 1'(src_present >> port_cur);
        rec_last  = !port_here || (phase == PH_W'(PAD_BYTES + 1));
        strm_last = rec_last && (port_cur == PORT_W'(NPORTS - 1));
        dbit      = 0;
        if (phase >= PH_W'(2))
            dbit = (int'(port_cur) * PAD_BYTES + PAD_BYTES + 1 - int'(phase)) * 8;
        cur_byte = 8'(src_data >> dbit);
        if (!port_here)
            cur_byte = 8'hF0;
        else if (phase == '0)
            cur_byte = 8'hF1;
        else if (phase == PH_W'(1))
            cur_byte = 8'(PAD_BYTES);
    end

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        idx_n   = idx;
        port_n  = port_cur;
        phase_n = phase;
        npe_n   = npe_q;
        pdl_n   = pdl_q;
        irq_n_n = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_n = ST_WAIT;
                    wait_n  = WCNT_W'(WAIT_CYC - 1);
                    pdl_n   = 1'b1;
                    npe_n   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_n = ST_FILL;
                    idx_n   = '0;
                    port_n  = '0;
                    phase_n = '0;
                end else begin
                    wait_n = wait_cnt - 1'b1;
                end
            end
            ST_FILL: begin
                wr_en   = 1'b1;
                wr_data = cur_byte;
                idx_n   = idx + 1'b1;
                if (rec_last) begin
                    port_n  = port_cur + 1'b1;
                    phase_n = '0;
                end else begin
                    phase_n = phase + 1'b1;
                end
                if (strm_last) begin
                    if (idx == 5'd31) begin
                        npe_n   = 1'b0;
                        irq_n_n = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_CLEAR;
                    end
                end else if (idx == 5'd31) begin
                    npe_n   = 1'b1;
                    irq_n_n = 1'b0;
                    state_n = ST_PAGE_WAIT;
                end
            end
            ST_CLEAR: begin
                wr_en = 1'b1;
                idx_n = idx + 1'b1;
                if (idx == 5'd31) begin
                    npe_n   = 1'b0;
                    irq_n_n = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            ST_PAGE_WAIT: begin
                if (BREAK) begin
                    npe_n   = 1'b0;
                    state_n = ST_IDLE;
                end else if (CONT) begin
                    pdl_n   = 1'b0;
                    idx_n   = '0;
                    state_n = ST_FILL;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= ST_IDLE;
        else if (CE)
            state <= state_n;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= '0;
            idx      <= '0;
            port_cur <= '0;
            phase    <= '0;
            npe_q    <= 1'b0;
            pdl_q    <= 1'b0;
            irq_q    <= 1'b1;
        end else if (CE) begin
            wait_cnt <= wait_n;
            idx      <= idx_n;
            port_cur <= port_n;
            phase    <= phase_n;
            npe_q    <= npe_n;
            pdl_q    <= pdl_n;
            irq_q    <= irq_n_n;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++)
                oreg[i] <= 8'h00;
        end else if (CE && wr_en) begin
            oreg[idx] <= wr_data;
        end
    end

    assign OREG_DATA = oreg[OREG_ADDR];
    assign BUSY      = (state != ST_IDLE);
    assign NPE       = npe_q;
    assign PDL       = pdl_q;
    assign IRQ_N     = irq_q;
endmodule

// File: tb/tb_smpc_periph_collector.sv
// Bench for smpc_periph_collector: a 2-port and a 12-port instance driven with random CE,
// checked against a byte-stream model of the peripheral format.
`timescale 1ns/1ps
module tb_smpc_periph_collector;
    localparam int NA = 2,  PA = 2, WA = 4;
    localparam int NB = 12, PB = 2, WB = 3;
`ifdef SMPC_PAD_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic CLK = 1'b0, RST_N = 1'b0, CE = 1'b0;
    logic START_A = 1'b0, START_B = 1'b0, CONT = 1'b0, BREAK = 1'b0;
    logic [NA-1:0]      PAD_PRESENT_A;
    logic [NA*PA*8-1:0] PAD_DATA_A;
    logic [NB-1:0]      PAD_PRESENT_B;
    logic [NB*PB*8-1:0] PAD_DATA_B;
    logic [4:0] OREG_ADDR_A = '0, OREG_ADDR_B = '0;
    logic [7:0] OREG_DATA_A, OREG_DATA_B;
    logic BUSY_A, NPE_A, PDL_A, IRQ_N_A, BUSY_B, NPE_B, PDL_B, IRQ_N_B;

    smpc_periph_collector #(.NPORTS(NA), .PAD_BYTES(PA), .WAIT_CYC(WA)) u_a (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(START_A), .CONT(CONT), .BREAK(BREAK),
        .PAD_PRESENT(PAD_PRESENT_A), .PAD_DATA(PAD_DATA_A), .OREG_ADDR(OREG_ADDR_A),
        .OREG_DATA(OREG_DATA_A), .BUSY(BUSY_A), .NPE(NPE_A), .PDL(PDL_A), .IRQ_N(IRQ_N_A));

    smpc_periph_collector #(.NPORTS(NB), .PAD_BYTES(PB), .WAIT_CYC(WB)) u_b (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(START_B), .CONT(CONT), .BREAK(BREAK),
        .PAD_PRESENT(PAD_PRESENT_B), .PAD_DATA(PAD_DATA_B), .OREG_ADDR(OREG_ADDR_B),
        .OREG_DATA(OREG_DATA_B), .BUSY(BUSY_B), .NPE(NPE_B), .PDL(PDL_B), .IRQ_N(IRQ_N_B));

    always #5 CLK = ~CLK;

    int ce_cnt = 0;
    int irq_at_a = -1, irq_at_b = -1;
    int n_pass = 0, n_total = 0;
    bit         pres_a [16];
    logic [7:0] dat_a  [16][16];
    bit         pres_b [16];
    logic [7:0] dat_b  [16][16];
    logic [7:0] strm [$];

    always @(posedge CLK) if (CE) ce_cnt <= ce_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // IRQ_N must be low exactly in the CE cycle following each page's last write.
    always @(negedge CLK) begin
        if (RST_N) begin
            chk("irq_n_a", int'(IRQ_N_A), (ce_cnt == irq_at_a) ? 0 : 1);
            chk("irq_n_b", int'(IRQ_N_B), (ce_cnt == irq_at_b) ? 0 : 1);
        end
    end

    function automatic void mk_stream(input bit which);
        int np = which ? NB : NA;
        int pb = which ? PB : PA;
        strm.delete();
        for (int p = 0; p < np; p++) begin
            if (which ? pres_b[p] : pres_a[p]) begin
                strm.push_back(8'hF1);
                strm.push_back(8'(pb));
                for (int k = 0; k < pb; k++)
                    strm.push_back(which ? dat_b[p][k] : dat_a[p][k]);
            end else begin
                strm.push_back(8'hF0);
            end
        end
    endfunction

    function automatic int exp_byte(input int page, input int i);
        int j = 32 * page + i;
        return (j < strm.size()) ? int'(strm[j]) : 0;
    endfunction

    task automatic pack();
        for (int p = 0; p < NA; p++) begin
            PAD_PRESENT_A[p] = pres_a[p];
            for (int k = 0; k < PA; k++) PAD_DATA_A[(p*PA + PA-1-k)*8 +: 8] = dat_a[p][k];
        end
        for (int p = 0; p < NB; p++) begin
            PAD_PRESENT_B[p] = pres_b[p];
            for (int k = 0; k < PB; k++) PAD_DATA_B[(p*PB + PB-1-k)*8 +: 8] = dat_b[p][k];
        end
    endtask

    task automatic step(input bit ce, input bit sa, input bit sb, input bit c, input bit b);
        CE = ce; START_A = sa; START_B = sb; CONT = c; BREAK = b;
        @(negedge CLK);
    endtask

    task automatic run_to(input int tgt);
        int guard = 0;
        while (ce_cnt < tgt && guard < 4000) begin
            step($urandom_range(0, 3) != 0, 0, 0, 0, 0);
            guard++;
        end
        if (ce_cnt != tgt) chk("run_to_timeout", ce_cnt, tgt);
    endtask

    task automatic freeze();
        CE = 1'b0; START_A = 1'b0; START_B = 1'b0; CONT = 1'b0; BREAK = 1'b0;
    endtask

    task automatic rd(input bit which, input int addr, output logic [7:0] v);
        if (which) OREG_ADDR_B = 5'(addr); else OREG_ADDR_A = 5'(addr);
        #1;
        v = which ? OREG_DATA_B : OREG_DATA_A;
    endtask

    task automatic check_page(input bit which, input int page, input string nm);
        logic [7:0] v;
        freeze();
        for (int i = 0; i < 32; i++) begin
            rd(which, i, v);
            chk($sformatf("%s_oreg[%0d]", nm, i), int'(v), exp_byte(page, i));
        end
        @(negedge CLK);
    endtask

    task automatic pin(input bit which, input int addr, input int val, input string nm);
        logic [7:0] v;
        freeze();
        rd(which, addr, v);
        chk(nm, int'(v), val);
        @(negedge CLK);
    endtask

    task automatic check_flags(input bit which, input int busy, input int npe, input int pdl,
                               input string nm);
        freeze();
        #1;
        chk({nm, "_busy"}, int'(which ? BUSY_B : BUSY_A), busy);
        chk({nm, "_npe"},  int'(which ? NPE_B : NPE_A), npe);
        chk({nm, "_pdl"},  int'(which ? PDL_B : PDL_A), pdl);
        chk({nm, "_irq"},  int'(which ? IRQ_N_B : IRQ_N_A),
            (ce_cnt == (which ? irq_at_b : irq_at_a)) ? 0 : 1);
        @(negedge CLK);
    endtask

    task automatic start_b(output int s);
        s = ce_cnt + 1;
        step(1, 0, 1, 0, 0);
        irq_at_b = s + WB + 32;
    endtask

    task automatic cont_b();
        int c = ce_cnt + 1;
        step(1, 0, 0, 1, 0);
        irq_at_b = c + 32;
    endtask

    task automatic rand_b(input bit all_present);
        for (int p = 0; p < 16; p++) begin
            pres_b[p] = all_present ? 1'b1 : bit'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++) dat_b[p][k] = 8'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int  s;
        bit  multi;
        for (int p = 0; p < 16; p++) begin
            pres_a[p] = 1'b0; pres_b[p] = 1'b0;
            for (int k = 0; k < 16; k++) begin dat_a[p][k] = 8'h00; dat_b[p][k] = 8'h00; end
        end
        pack();
        repeat (3) @(negedge CLK);

        // Reset state of both instances
        strm.delete();
        check_page(0, 0, "rst_a");
        check_page(1, 0, "rst_b");
        check_flags(0, 0, 0, 0, "rst_a");
        check_flags(1, 0, 0, 0, "rst_b");
        RST_N = 1'b1;
        @(negedge CLK);

        // Two present pads, single page
        pres_a[0] = 1; pres_a[1] = 1;
        dat_a[0][0] = 8'hFF; dat_a[0][1] = 8'hFE; dat_a[1][0] = 8'h7F; dat_a[1][1] = 8'hFF;
        pack(); mk_stream(0);
        chk("model_len_t1", strm.size(), 8);
        s = ce_cnt + 1; step(1, 1, 0, 0, 0); irq_at_a = s + WA + 32;
        run_to(irq_at_a + 1);
        check_page(0, 0, "t1");
        check_flags(0, 0, 0, 1, "t1");
        pin(0, 0, 8'hF1, "t1_lit0"); pin(0, 1, 8'h02, "t1_lit1"); pin(0, 3, 8'hFE, "t1_lit3");
        pin(0, 6, 8'h7F, "t1_lit6"); pin(0, 8, 8'h00, "t1_lit8");

        // Port 1 absent; CONT in WAIT and START in FILL must both be ignored
        pres_a[1] = 0;
        pack(); mk_stream(0);
        chk("model_len_t2", strm.size(), 5);
        s = ce_cnt + 1; step(1, 1, 0, 0, 0); irq_at_a = s + WA + 32;
        run_to(s + 1);
        step(1, 0, 0, 1, 0);
        run_to(s + WA + 2);
        step(1, 1, 0, 0, 0);
        run_to(irq_at_a + 1);
        check_page(0, 0, "t2");
        check_flags(0, 0, 0, 1, "t2");
        pin(0, 4, 8'hF0, "t2_lit4"); pin(0, 5, 8'h00, "t2_lit5");

        // 12 present ports: two pages, pad data changes between pages
        rand_b(1'b1); pack(); mk_stream(1);
        chk("model_len_t3", strm.size(), 48);
        start_b(s);
        run_to(irq_at_b + 1);
        check_page(1, 0, "t3_p0");
        check_flags(1, 1, 1, 1, "t3_p0");
        pin(1, 28, 8'hF1, "t3_lit28"); pin(1, 29, 8'h02, "t3_lit29");
        for (int p = 0; p < NB; p++)
            for (int k = 0; k < PB; k++) dat_b[p][k] = ~dat_b[p][k];
        pack();
        if (!SNAP) mk_stream(1);
        cont_b();
        run_to(irq_at_b + 1);
        check_page(1, 1, "t3_p1");
        check_flags(1, 0, 0, 0, "t3_p1");
        pin(1, 0, 8'hF1, "t3_lit_p1_0"); pin(1, 16, 8'h00, "t3_lit_p1_16");

        // BREAK together with CONT in PAGE_WAIT: abort, keep page 1, no IRQ
        rand_b(1'b1); pack(); mk_stream(1);
        start_b(s);
        run_to(irq_at_b + 1);
        check_page(1, 0, "t4_p0");
        step(1, 0, 0, 1, 1);
        run_to(ce_cnt + 3);
        check_flags(1, 0, 0, 1, "t4_brk");
        check_page(1, 0, "t4_keep");

        // Reset in the middle of FILL
        rand_b(1'b1); pack(); mk_stream(1);
        start_b(s);
        run_to(s + WB + 6);
        RST_N = 1'b0; irq_at_a = -1; irq_at_b = -1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        strm.delete();
        check_page(1, 0, "t5");
        check_flags(1, 0, 0, 0, "t5_b");
        check_flags(0, 0, 0, 0, "t5_a");
        RST_N = 1'b1;
        @(negedge CLK);

        // Random presence patterns with random CONT/BREAK choices
        for (int t = 0; t < 8; t++) begin
            rand_b(1'b0); pack(); mk_stream(1);
            multi = strm.size() > 32;
            start_b(s);
            run_to(irq_at_b + 1);
            check_page(1, 0, $sformatf("rnd%0d_p0", t));
            check_flags(1, int'(multi), int'(multi), 1, $sformatf("rnd%0d_p0", t));
            if (multi) begin
                if ($urandom_range(0, 1) == 1) begin
                    cont_b();
                    run_to(irq_at_b + 1);
                    check_page(1, 1, $sformatf("rnd%0d_p1", t));
                    check_flags(1, 0, 0, 0, $sformatf("rnd%0d_p1", t));
                end else begin
                    step(1, 0, 0, bit'($urandom_range(0, 1)), 1);
                    run_to(ce_cnt + 2);
                    check_page(1, 0, $sformatf("rnd%0d_keep", t));
                    check_flags(1, 0, 0, 1, $sformatf("rnd%0d_brk", t));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
